// File: rtl/bsg_wormhole_router_input_control_vc.sv
// Wormhole input control for one router input port shared by vc_p virtual
// channels. Each VC independently detects packet headers, counts down the
// body flits, holds the packet's route while the packet is in flight, pulses
// release on the last flit and flags protocol errors stickily.
module bsg_wormhole_router_input_control_vc #(
  parameter int vc_p               = 2,
  parameter int output_dirs_p      = 3,
  parameter int payload_len_bits_p = 3
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [vc_p-1:0]                      fifo_v_i,
  input  logic [vc_p*output_dirs_p-1:0]        fifo_decoded_dest_i,
  input  logic [vc_p*payload_len_bits_p-1:0]   fifo_payload_len_i,
  input  logic [vc_p-1:0]                      fifo_yumi_i,
  output logic [vc_p*output_dirs_p-1:0]        reqs_o,
  output logic [vc_p*output_dirs_p-1:0]        route_r_o,
  output logic [vc_p-1:0]                      detected_header_o,
  output logic [vc_p-1:0]                      release_o,
  output logic [vc_p-1:0]                      busy_o,
  output logic [vc_p-1:0]                      err_o
);

  localparam logic [payload_len_bits_p-1:0] len_zero_lp = '0;
  localparam logic [payload_len_bits_p-1:0] len_one_lp  = payload_len_bits_p'(1);
  localparam logic [output_dirs_p-1:0]      dest_zero_lp = '0;
  localparam logic [output_dirs_p-1:0]      dest_one_lp  = output_dirs_p'(1);

  for (genvar gi = 0; gi < vc_p; gi++) begin : g_vc
    logic [payload_len_bits_p-1:0] ctr_reg, ctr_next;
    logic [output_dirs_p-1:0]      route_reg, route_next;
    logic                          err_reg, err_next;

    logic [output_dirs_p-1:0]      dest;
    logic [payload_len_bits_p-1:0] len;
    logic                          idle;
    logic                          hdr_deq;
    logic                          body_deq;
    logic                          last_body;
    logic                          dest_onehot;

    assign dest        = fifo_decoded_dest_i[gi*output_dirs_p +: output_dirs_p];
    assign len         = fifo_payload_len_i[gi*payload_len_bits_p +: payload_len_bits_p];
    assign idle        = (ctr_reg == len_zero_lp);
    assign hdr_deq     = fifo_yumi_i[gi] & idle;
    assign body_deq    = fifo_yumi_i[gi] & ~idle;
    assign last_body   = (ctr_reg == len_one_lp);
    // A nonzero value with no second bit set: x & (x-1) clears the lowest one.
    assign dest_onehot = (dest != dest_zero_lp) &&
                         ((dest & (dest - dest_one_lp)) == dest_zero_lp);

    // Next-state: load length and route on header, count down on body flits.
    always_comb begin
      ctr_next   = ctr_reg;
      route_next = route_reg;
      err_next   = err_reg;
      if (hdr_deq) begin
        ctr_next = len;
        // Single-flit packets never occupy the VC, so their route is not held.
        if (len != len_zero_lp) begin
          route_next = dest;
        end
        if (!dest_onehot) begin
          err_next = 1'b1;
        end
      end else if (body_deq) begin
        ctr_next = ctr_reg - len_one_lp;
        if (last_body) begin
          route_next = dest_zero_lp;
        end
      end
      // Dequeue without a valid head still advances state, but is flagged.
      if (fifo_yumi_i[gi] && !fifo_v_i[gi]) begin
        err_next = 1'b1;
      end
    end

    // Per-VC state register with asynchronous clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        ctr_reg   <= len_zero_lp;
        route_reg <= dest_zero_lp;
        err_reg   <= 1'b0;
      end else begin
        ctr_reg   <= ctr_next;
        route_reg <= route_next;
        err_reg   <= err_next;
      end
    end

    assign detected_header_o[gi] = fifo_v_i[gi] & idle;
    assign reqs_o[gi*output_dirs_p +: output_dirs_p] =
      detected_header_o[gi] ? dest : dest_zero_lp;
    assign route_r_o[gi*output_dirs_p +: output_dirs_p] = route_reg;
    assign release_o[gi] = (hdr_deq & (len == len_zero_lp)) | (body_deq & last_body);
    assign busy_o[gi]    = ~idle;
    assign err_o[gi]     = err_reg;
  end

endmodule

// File: doc/bsg_wormhole_router_input_control_vc.md
Name: bsg_wormhole_router_input_control_vc

Overview:
- Per-input-port wormhole control for a router input shared by vc_p virtual channels, each with its own input FIFO head.
- Each VC tracks packet boundaries independently: header detection, a body-flit countdown, latching of the route for the packet's duration, and an explicit last-flit release pulse.
- Sits between the per-VC input FIFOs / route decoders and the output-direction arbiters.
- Generalises the single-channel input control:
  - Parametrised VC count, direction count and length width.
  - Adds a latched route output, a last-flit release pulse and sticky protocol-error detection.

Parameters:
- vc_p, 2, number of virtual channels (>=1)
- output_dirs_p, 3, number of output directions (width of one-hot dest)
- payload_len_bits_p, 3, width of payload length field (body flits following header)

Ports:
- clk_i  in  1  clock; all state updates on posedge
- reset_n_i  in  1  asynchronous active-low reset
- fifo_v_i  in  vc_p  per-VC FIFO head valid
- fifo_decoded_dest_i  in  vc_p*output_dirs_p  per-VC one-hot dest of head flit; VC v at bits [v*output_dirs_p +: output_dirs_p]
- fifo_payload_len_i  in  vc_p*payload_len_bits_p  per-VC payload length of head flit, meaningful only on headers
- fifo_yumi_i  in  vc_p  per-VC dequeue of head flit this cycle
- reqs_o  out  vc_p*output_dirs_p  per-VC output-direction request
- route_r_o  out  vc_p*output_dirs_p  per-VC latched route of the packet in flight
- detected_header_o  out  vc_p  head flit of VC v is a valid header
- release_o  out  vc_p  one-cycle pulse: last flit of VC v's packet dequeued
- busy_o  out  vc_p  VC v has a packet in progress (body flits outstanding)
- err_o  out  vc_p  sticky protocol error per VC

Behaviour:
- Reset: asynchronous, taken while reset_n_i=0. Clears every VC's counter, route_r_o, busy state and err_o. Combinational outputs then follow from that cleared state.
- Per-VC state:
  - Counter ctr[v], payload_len_bits_p wide.
  - VC is idle when ctr[v]==0; busy_o[v] = (ctr[v]!=0), registered-derived.
- detected_header_o[v] = fifo_v_i[v] & idle[v] (combinational).
- reqs_o[v] = detected_header_o[v] ? fifo_decoded_dest_i[v] : 0 (combinational; no added latency).
- Header dequeue, fifo_yumi_i[v] & idle[v]:
  - ctr[v] <= fifo_payload_len_i[v].
  - route_r_o[v] <= fifo_decoded_dest_i[v], only if payload len != 0.
- Body dequeue, fifo_yumi_i[v] & busy[v]:
  - ctr[v] <= ctr[v]-1.
  - When ctr[v] reaches 0, route_r_o[v] <= 0 on the same edge.
- release_o[v] is combinational, asserted in the cycle of the last-flit yumi:
  - Idle: yumi with payload len==0 (single-flit packet).
  - Busy: yumi with ctr[v]==1.
  - Never asserted otherwise.
- Back-to-back packets:
  - After a last-flit yumi, the VC is idle on the next cycle.
  - A new header may be requested and dequeued on that cycle, so there are no bubbles.
- Max length: payload len of 2^payload_len_bits_p-1 is legal; the counter never wraps.
- err_o[v] is set (sticky until reset) when either:
  - fifo_yumi_i[v] & ~fifo_v_i[v], or
  - a header with a non-one-hot (zero or multi-hot) dest is dequeued.
- On an erroneous yumi without valid, state still updates as if a flit had been dequeued; this keeps behaviour deterministic.
- VCs are fully independent. Simultaneous yumis on different VCs are legal and processed in parallel.
- Reset asserted mid-packet: all VCs are immediately idle. A subsequent head flit is treated as a header; upstream must flush FIFOs.

Test Plan:
- Reset behaviour:
  - Stimulus: reset_n_i=0, then release; fifo_v_i=0.
  - Response: all outputs 0.
  - Stimulus: fifo_v_i[0]=1, dest0=3'b010.
  - Response: reqs_o[0]=3'b010, detected_header_o[0]=1.
- Single-flit packet (vc_p=2, output_dirs_p=3, payload_len_bits_p=3):
  - Stimulus: VC0 header, len=0, dest=3'b001, yumi.
  - Response: release_o[0]=1 the same cycle; busy_o[0] stays 0; route_r_o[0] stays 0.
- Multi-flit packet:
  - Stimulus: VC1 header, len=3, dest=3'b100, yumi; then 3 body yumis.
  - Response: route_r_o[1]=3'b100 and busy_o[1]=1 for 3 cycles; reqs_o[1]=0 during body; release_o[1] only on the 3rd body yumi; next header requested the following cycle.
- Independence:
  - Stimulus: VC0 mid-packet (ctr=2) while VC1 receives header len=7.
  - Response: both counters correct; VC1 releases after 7 body yumis; max-len case, no wrap.
- Errors:
  - Stimulus: yumi on VC0 with fifo_v_i[0]=0.
  - Response: err_o[0]=1 and it persists.
  - Stimulus: header with dest=3'b011.
  - Response: err_o set; other VC's err_o remains 0.
- Async reset mid-packet:
  - Stimulus: drop reset_n_i between clock edges while VC1 ctr=4.
  - Response: busy_o, route_r_o and release_o go to 0 immediately, without waiting for a clock edge.
